// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder slice.
package mem_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  strb_t;
  typedef logic [31:0] addr_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } rd_state_e;

  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/mem_array.sv
// Word-organised RAM: one registered read port, one byte-enabled write port, read-first.
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter string       INIT_FILE   = ""
) (
  input  logic                           clk_i,
  input  logic                           rd_en_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] rd_idx_i,
  output word_t                          rd_data_o,
  input  logic                           wr_en_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] wr_idx_i,
  input  word_t                          wr_data_i,
  input  strb_t                          wr_strb_i
);

  word_t mem_q [DEPTH_WORDS];
  word_t rd_data_q;

  // Read and write share one edge; non-blocking semantics give read-first.
  always_ff @(posedge clk_i) begin
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_idx_i];
    end
    if (wr_en_i) begin
      for (int unsigned b = 0; b < WORD_BYTES; b++) begin
        if (wr_strb_i[b]) begin
          mem_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
        end
      end
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side endpoint: single-outstanding read FSM with fixed latency, always-ready writes.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned READ_LATENCY = 2,
  parameter string       INIT_FILE    = ""
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rd_req_valid_i,
  output logic        rd_req_ready_o,
  input  logic [31:0] rd_addr_i,
  output logic        rd_rsp_valid_o,
  input  logic        rd_rsp_ready_i,
  output logic [31:0] rd_data_o,
  output logic        rd_err_o,
  input  logic        wr_valid_i,
  output logic        wr_ready_o,
  input  logic [31:0] wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic [3:0]  wr_strb_i,
  output logic        wr_err_o
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(READ_LATENCY - 1);

  rd_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        wr_err_q, wr_err_d;
  logic        rd_accept;
  logic        rd_in_range, wr_in_range;
  logic        wr_en;
  word_t       snap_data;
  logic        unused_addr_bits;

  // Upper-bit test is exactly addr < 4*DEPTH_WORDS for a power-of-two depth.
  assign rd_in_range      = (rd_addr_i[31:AW+2] == '0);
  assign wr_in_range      = (wr_addr_i[31:AW+2] == '0);
  assign unused_addr_bits = ^{rd_addr_i[1:0], wr_addr_i[1:0]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    rd_accept = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_req_valid_i) begin
          rd_accept = 1'b1;
          err_d     = ~rd_in_range;
          cnt_d     = CNT_INIT;
          state_d   = (READ_LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rd_rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_en    = wr_valid_i & wr_in_range;
  assign wr_err_d = wr_valid_i & ~wr_in_range;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      wr_err_q <= wr_err_d;
    end
  end

  // The array's read register doubles as the response snapshot: it only loads on accept.
  mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE)
  ) u_array (
    .clk_i     (clk_i),
    .rd_en_i   (rd_accept),
    .rd_idx_i  (rd_addr_i[AW+1:2]),
    .rd_data_o (snap_data),
    .wr_en_i   (wr_en),
    .wr_idx_i  (wr_addr_i[AW+1:2]),
    .wr_data_i (wr_data_i),
    .wr_strb_i (wr_strb_i)
  );

  assign rd_req_ready_o = (state_q == IDLE);
  assign rd_rsp_valid_o = (state_q == RESP);
  assign rd_err_o       = rd_rsp_valid_o & err_q;
  assign rd_data_o      = (rd_rsp_valid_o & ~err_q) ? snap_data : '0;
  assign wr_ready_o     = 1'b1;
  assign wr_err_o       = wr_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a word-array reference model.
module tb_mem_responder;
  import mem_pkg::*;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH);

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        rd_req_valid_i;
  logic        rd_req_ready_o;
  logic [31:0] rd_addr_i;
  logic        rd_rsp_valid_o;
  logic        rd_rsp_ready_i;
  logic [31:0] rd_data_o;
  logic        rd_err_o;
  logic        wr_valid_i;
  logic        wr_ready_o;
  logic [31:0] wr_addr_i;
  logic [31:0] wr_data_i;
  logic [3:0]  wr_strb_i;
  logic        wr_err_o;

  always #5 clk_i = ~clk_i;

  mem_responder #(
    .DEPTH_WORDS  (DEPTH),
    .READ_LATENCY (LAT),
    .INIT_FILE    ("")
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .rd_req_valid_i (rd_req_valid_i),
    .rd_req_ready_o (rd_req_ready_o),
    .rd_addr_i      (rd_addr_i),
    .rd_rsp_valid_o (rd_rsp_valid_o),
    .rd_rsp_ready_i (rd_rsp_ready_i),
    .rd_data_o      (rd_data_o),
    .rd_err_o       (rd_err_o),
    .wr_valid_i     (wr_valid_i),
    .wr_ready_o     (wr_ready_o),
    .wr_addr_i      (wr_addr_i),
    .wr_data_i      (wr_data_i),
    .wr_strb_i      (wr_strb_i),
    .wr_err_o       (wr_err_o)
  );

  int    n_cmp = 0;
  int    n_bad = 0;
  word_t ref_mem [DEPTH];
  logic  exp_wr_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic word_t ref_read(input addr_t a);
    return (a < LIMIT) ? ref_mem[a / 4] : '0;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
    check("wr_err", 32'(wr_err_o), 32'(exp_wr_err));
    exp_wr_err = 1'b0;
    wr_valid_i = 1'b0;
    wr_addr_i  = $urandom;
    wr_data_i  = $urandom;
    wr_strb_i  = 4'($urandom);
  endtask

  task automatic set_write(input addr_t a, input word_t d, input strb_t s);
    wr_valid_i = 1'b1;
    wr_addr_i  = a;
    wr_data_i  = d;
    wr_strb_i  = s;
    if (a < LIMIT) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) ref_mem[a / 4][8*b +: 8] = d[8*b +: 8];
      end
    end
    exp_wr_err = (a >= LIMIT);
  endtask

  task automatic do_write(input addr_t a, input word_t d, input strb_t s);
    set_write(a, d, s);
    tick();
  endtask

  task automatic do_read(input addr_t a, input int bp, input bit coll, input word_t cd,
                         input strb_t cs, input bit wwr, output word_t got_d, output logic got_e);
    word_t exp_d;
    logic  exp_e;
    int    n;
    exp_e = (a >= LIMIT);
    exp_d = ref_read(a);
    rd_rsp_ready_i = 1'b0;
    check("req_ready_idle", 32'(rd_req_ready_o), 32'd1);
    rd_req_valid_i = 1'b1;
    rd_addr_i      = a;
    if (coll) set_write(a, cd, cs);
    tick();
    rd_req_valid_i = 1'b0;
    rd_addr_i      = $urandom;
    n = 0;
    while (!rd_rsp_valid_o && n < 40) begin
      check("req_ready_wait", 32'(rd_req_ready_o), 32'd0);
      check("data_idle_zero", rd_data_o, 32'd0);
      if (wwr) set_write(a, $urandom, 4'hF);
      tick();
      n++;
    end
    check("latency", 32'(n + 1), 32'(LAT));
    for (int i = 0; i < bp; i++) begin
      check("bp_valid", 32'(rd_rsp_valid_o), 32'd1);
      check("bp_req_ready", 32'(rd_req_ready_o), 32'd0);
      check("bp_data", rd_data_o, exp_d);
      check("bp_err", 32'(rd_err_o), 32'(exp_e));
      if (wwr) set_write(a, $urandom, 4'($urandom));
      tick();
    end
    check("rsp_data", rd_data_o, exp_d);
    check("rsp_err", 32'(rd_err_o), 32'(exp_e));
    got_d = rd_data_o;
    got_e = rd_err_o;
    rd_rsp_ready_i = 1'b1;
    tick();
    rd_rsp_ready_i = 1'b0;
    check("rsp_drop", 32'(rd_rsp_valid_o), 32'd0);
    check("req_ready_after", 32'(rd_req_ready_o), 32'd1);
    check("data_after_zero", rd_data_o, 32'd0);
    check("err_after_zero", 32'(rd_err_o), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    word_t gd;
    logic  ge;
    addr_t ra;

    rst_i          = 1'b1;
    rd_req_valid_i = 1'b0;
    rd_addr_i      = '0;
    rd_rsp_ready_i = 1'b0;
    wr_valid_i     = 1'b0;
    wr_addr_i      = '0;
    wr_data_i      = '0;
    wr_strb_i      = '0;
    tick();
    tick();
    check("rst_req_ready", 32'(rd_req_ready_o), 32'd1);
    check("rst_rsp_valid", 32'(rd_rsp_valid_o), 32'd0);
    check("rst_data", rd_data_o, 32'd0);
    check("rst_err", 32'(rd_err_o), 32'd0);
    check("rst_wr_ready", 32'(wr_ready_o), 32'd1);
    rst_i = 1'b0;
    tick();

    for (int i = 0; i < 64; i++) do_write(addr_t'(i * 4), $urandom, 4'hF);

    // write then read back
    do_write(32'h10, 32'hDEADBEEF, 4'hF);
    do_read(32'h10, 0, 1'b0, '0, '0, 1'b0, gd, ge);
    check("wb_data", gd, 32'hDEADBEEF);
    check("wb_err", 32'(ge), 32'd0);

    // byte strobe merge
    do_write(32'h10, 32'h00AA0000, 4'h4);
    do_read(32'h10, 0, 1'b0, '0, '0, 1'b0, gd, ge);
    check("strb_data", gd, 32'hDEAABEEF);

    // zero strobe is a no-op
    do_write(32'h10, 32'h12345678, 4'h0);
    do_read(32'h10, 5, 1'b0, '0, '0, 1'b0, gd, ge);
    check("strb0_bp_data", gd, 32'hDEAABEEF);

    // same-cycle collision is read-first
    do_write(32'h20, 32'h11111111, 4'hF);
    do_read(32'h20, 0, 1'b1, 32'h22222222, 4'hF, 1'b0, gd, ge);
    check("coll_old", gd, 32'h11111111);
    do_read(32'h20, 0, 1'b0, '0, '0, 1'b0, gd, ge);
    check("coll_new", gd, 32'h22222222);

    // out of range
    do_read(32'h1000, 2, 1'b0, '0, '0, 1'b0, gd, ge);
    check("oor_rd_data", gd, 32'd0);
    check("oor_rd_err", 32'(ge), 32'd1);
    gd = ref_mem[0];
    do_write(32'h1000, 32'hCAFEF00D, 4'hF);
    tick();
    do_read(32'h0, 0, 1'b0, '0, '0, 1'b0, ge == 1'b1 ? gd : gd, ge);
    check("oor_wr_word0", gd, ref_mem[0]);

    // reset one cycle after read accept
    check("rstw_ready", 32'(rd_req_ready_o), 32'd1);
    rd_req_valid_i = 1'b1;
    rd_addr_i      = 32'h10;
    tick();
    rd_req_valid_i = 1'b0;
    rst_i          = 1'b1;
    #1;
    check("rstw_valid_now", 32'(rd_rsp_valid_o), 32'd0);
    check("rstw_ready_now", 32'(rd_req_ready_o), 32'd1);
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rstw_no_rsp", 32'(rd_rsp_valid_o), 32'd0);
      check("rstw_ready_hold", 32'(rd_req_ready_o), 32'd1);
      tick();
    end
    do_read(32'h10, 0, 1'b0, '0, '0, 1'b0, gd, ge);
    check("rstw_ram_kept", gd, 32'hDEAABEEF);

    // randomized mix
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 9) < 2) begin
        ra = $urandom;
        if (ra < LIMIT) ra = ra | LIMIT;
      end else begin
        ra = addr_t'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 1) == 0) begin
        do_write(ra, $urandom, 4'($urandom));
      end else begin
        do_read(ra, int'($urandom_range(0, 4)), 1'($urandom), $urandom, 4'($urandom),
                1'($urandom), gd, ge);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
